// File: rtl/cache_req_sequencer.sv
// Request front-end for the 16-block direct-mapped cache: queues read addresses,
// issues them one at a time, captures hit/data into a valid/ready response and keeps hit/miss statistics.
module cache_req_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  input  logic [10:0]                   req_addr,
  output logic                          req_ready,
  output logic                          cache_read,
  output logic [10:0]                   cache_addr,
  input  logic                          cache_hit,
  input  logic [10:0]                   cache_read_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [10:0]                   rsp_addr,
  output logic                          rsp_hit,
  output logic [10:0]                   rsp_data,
  output logic [CNT_W-1:0]              hit_count,
  output logic [CNT_W-1:0]              miss_count,
  input  logic                          clear_stats,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      DEPTH_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [10:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              cache_read_q, cache_read_d;
  logic [10:0]       cache_addr_q, cache_addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [10:0]       rsp_addr_q, rsp_addr_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic [10:0]       rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic              full, empty, push, pop;
  logic [10:0]       head;

  // req_ready deliberately ignores a same-cycle pop so it is a pure function of the level register.
  assign full  = (level_q == DEPTH_LVL);
  assign empty = (level_q == '0);
  assign push  = req_valid && !full;
  assign head  = fifo_mem[rd_ptr_q];

  // Storage is not reset; only pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= req_addr;
    end
  end

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    cache_read_d = 1'b0;
    cache_addr_d = cache_addr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_addr_d   = rsp_addr_q;
    rsp_hit_d    = rsp_hit_q;
    rsp_data_d   = rsp_data_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          cache_addr_d = head;
          cache_read_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        rsp_addr_d  = cache_addr_q;
        rsp_hit_d   = cache_hit;
        rsp_data_d  = cache_read_data;
        rsp_valid_d = 1'b1;
        if (cache_hit) begin
          if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + 1'b1;
        end else begin
          if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A clear swallows any increment landing in the same cycle.
    if (clear_stats) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      cache_read_q <= 1'b0;
      cache_addr_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_addr_q   <= '0;
      rsp_hit_q    <= 1'b0;
      rsp_data_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      cache_read_q <= cache_read_d;
      cache_addr_q <= cache_addr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_data_q   <= rsp_data_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign req_ready  = !full;
  assign cache_read = cache_read_q;
  assign cache_addr = cache_addr_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_addr   = rsp_addr_q;
  assign rsp_hit    = rsp_hit_q;
  assign rsp_data   = rsp_data_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign fifo_level = level_q;
  assign busy       = (state_q != IDLE) || !empty;

endmodule
